// File: rtl/xeng_acc_pkg.sv
// Shared sizing helpers and default constants for the X-engine accumulator unload path.
// The functions let each instance derive widths from its own parameters.
package xeng_acc_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int wbits(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

  function automatic int cw_f(input int bw, input int pfb, input int salb);
    return 2 * bw + 1 + pfb + salb;
  endfunction

  function automatic int n_bl_f(input int na);
    return na * ((na >> 1) + 1);
  endfunction

  localparam int N_STOKES  = 2 * 2;
  localparam int CW        = cw_f(4, 2, 7);
  localparam int ACC_WIDTH = N_STOKES * 2 * CW;
  localparam int N_BL      = n_bl_f(32);
  localparam int BLW       = clog2(N_BL);

  typedef enum logic {
    IDLE,
    EMIT
  } unload_state_e;

endpackage

// File: rtl/xeng_acc_unload_if.sv
// Output beat bundle of the accumulator unloader: one Stokes product per beat.
// Master drives data/tags/valid, slave returns ready.
interface xeng_acc_unload_if
  import xeng_acc_pkg::*;
#(
  parameter int DW = 2 * CW,
  parameter int SW = wbits(N_STOKES),
  parameter int BW = BLW
) ();

  logic [DW-1:0] out_data;
  logic [SW-1:0] out_stokes;
  logic [BW-1:0] out_bl;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data,
    output out_stokes,
    output out_bl,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_stokes,
    input  out_bl,
    input  out_last,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/xeng_acc_unload_fifo.sv
// Synchronous word FIFO holding accumulation words with their baseline tags.
// Read data is the head entry, valid whenever empty is low.
module acc_word_fifo
  import xeng_acc_pkg::*;
#(
  parameter int W          = ACC_WIDTH + BLW,
  parameter int DEPTH_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [W-1:0]        mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                 (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
  assign rd_data = mem[rd_ptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (ce) begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (ce && wr_en) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
  end

endmodule

// File: rtl/xeng_acc_unload.sv
// Captures tap-chain accumulation words, tags them by baseline, buffers them
// and serializes each word into per-Stokes beats on a valid/ready port.
module xeng_acc_unload
  import xeng_acc_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 2,
  parameter int BITWIDTH            = 4,
  parameter int N_POLS              = 2,
  parameter int N_ANTS              = 32,
  parameter int FIFO_DEPTH_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 sync_in,
  input  logic [N_POLS*N_POLS*2*
    cw_f(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS)-1:0] acc_in,
  input  logic                 valid_in,
  xeng_acc_unload_if.master    dout,
  output logic                 overflow
);

  localparam int NSTK  = N_POLS * N_POLS;
  localparam int CWID  = cw_f(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS);
  localparam int DWID  = 2 * CWID;
  localparam int ACCW  = NSTK * DWID;
  localparam int NBL   = n_bl_f(N_ANTS);
  localparam int BLWID = clog2(NBL);
  localparam int SWID  = wbits(NSTK);
  localparam int FWID  = ACCW + BLWID;

  unload_state_e state_q;
  unload_state_e state_d;

  logic [BLWID-1:0] bl_cnt;
  logic [BLWID-1:0] tag;
  logic [FWID-1:0]  rd_data;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             full;
  logic             empty;
  logic             emit;
  logic             beat;
  logic             last_beat;

  logic [ACCW-1:0]  word_q;
  logic [SWID-1:0]  stokes_q;
  logic [BLWID-1:0] bl_q;
  logic             ovf_q;

  // A sync coincident with a word tags that word as baseline 0.
  assign tag       = sync_in ? '0 : bl_cnt;
  assign push      = ce & valid_in;
  assign wr_en     = push & (~full | pop);
  assign emit      = (state_q == EMIT);
  assign beat      = ce & emit & dout.out_ready;
  assign last_beat = (stokes_q == SWID'(NSTK - 1));

  acc_word_fifo #(
    .W          (FWID),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .wr_en   (wr_en),
    .wr_data ({tag, acc_in}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce && !empty) begin
          pop     = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (beat && last_beat) begin
          if (!empty) pop     = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      stokes_q <= '0;
      bl_q     <= '0;
    end else if (ce) begin
      if (pop) begin
        word_q   <= rd_data[ACCW-1:0];
        bl_q     <= rd_data[FWID-1 -: BLWID];
        stokes_q <= '0;
      end else if (beat) begin
        stokes_q <= last_beat ? '0 : stokes_q + 1'b1;
      end
    end
  end

  // Dropped words still consume a baseline slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl_cnt <= '0;
      ovf_q  <= 1'b0;
    end else if (ce) begin
      if (push)
        bl_cnt <= (tag == BLWID'(NBL - 1)) ? '0 : tag + 1'b1;
      else if (sync_in)
        bl_cnt <= '0;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign dout.out_data   = word_q[int'(stokes_q)*DWID +: DWID];
  assign dout.out_stokes = stokes_q;
  assign dout.out_bl     = bl_q;
  assign dout.out_valid  = emit;
  assign dout.out_last   = emit & last_beat & (bl_q == BLWID'(NBL - 1));
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_xeng_acc_unload.sv
// Directed bench for xeng_acc_unload: latency, tagging, stall, overflow,
// reset and sync behaviour against hand-derived expectations.
module tb_xeng_acc_unload;
  import xeng_acc_pkg::*;

  localparam int DW = 2 * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic sync_in = 1'b0;
  logic valid_in = 1'b0;
  logic overflow;
  logic [ACC_WIDTH-1:0] acc_in = '0;

  int n_chk = 0;
  int n_pass = 0;

  xeng_acc_unload_if #(.DW(DW), .SW(2), .BW(BLW)) dout ();

  xeng_acc_unload dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .sync_in  (sync_in),
    .acc_in   (acc_in),
    .valid_in (valid_in),
    .dout     (dout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]  q_data [$];
  logic [1:0]     q_stk  [$];
  logic [BLW-1:0] q_bl   [$];
  logic           q_last [$];

  always @(negedge clk) begin
    if (dout.out_valid && dout.out_ready) begin
      q_data.push_back(dout.out_data);
      q_stk.push_back(dout.out_stokes);
      q_bl.push_back(dout.out_bl);
      q_last.push_back(dout.out_last);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mk(input int re, input int im);
    logic [CW-1:0] r;
    logic [CW-1:0] i;
    r = CW'(re);
    i = CW'(im);
    return {r, i};
  endfunction

  function automatic logic [ACC_WIDTH-1:0] acc_pat(input int base);
    logic [ACC_WIDTH-1:0] a;
    a = '0;
    for (int s = 0; s < N_STOKES; s++)
      a[s*DW +: DW] = mk(base + s, -(base + s));
    return a;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ACC_WIDTH-1:0] a, input logic s);
    valid_in = 1'b1;
    sync_in  = s;
    acc_in   = a;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sync_in  = 1'b0;
  endtask

  task automatic clr();
    q_data.delete();
    q_stk.delete();
    q_bl.delete();
    q_last.delete();
  endtask

  task automatic wait_stk(input int s, input string tag);
    int n;
    n = 0;
    while (!(dout.out_valid && dout.out_stokes == 2'(s)) && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  int errs;
  int nw;
  logic [BLW-1:0] nt;
  logic [DW-1:0] hold_d;
  logic [1:0] hold_s;
  logic stable;
  int wtag [$];
  logic [DW-1:0] wdat [$];

  task automatic collect();
    wtag.delete();
    wdat.delete();
    for (int i = 0; i < q_stk.size(); i++)
      if (q_stk[i] == 2'd0) begin
        wtag.push_back(int'(q_bl[i]));
        wdat.push_back(q_data[i]);
      end
  endtask

  initial begin
    dout.out_ready = 1'b1;
    step(2);
    chk("rst_valid", dout.out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_last", dout.out_last, 0);
    chk("rst_tags", {dout.out_stokes, dout.out_bl}, 0);
    chk("rst_data", dout.out_data, 0);
    rst_n = 1'b1;
    step(2);

    clr();
    push(acc_pat(1), 1'b0);
    chk("lat_t1_idle", dout.out_valid, 0);
    step(1);
    chk("s0_literal", dout.out_data, 64'h7FFFF);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("single_beat%0d", s),
          {dout.out_valid, dout.out_stokes, dout.out_bl, dout.out_last,
           dout.out_data},
          {1'b1, 2'(s), 10'd0, 1'b0, mk(s + 1, -(s + 1))});
      step(1);
    end
    chk("single_done", dout.out_valid, 0);

    clr();
    push(acc_pat(0), 1'b1);
    for (int i = 1; i < N_BL; i++) begin
      step(3);
      push(acc_pat(i), 1'b0);
    end
    step(3);
    push(acc_pat(7), 1'b0);
    step(12);
    chk("win_beats", q_stk.size(), (N_BL + 1) * 4);
    errs = 0;
    for (int i = 0; i < q_stk.size() && i < (N_BL + 1) * 4; i++) begin
      if (q_stk[i] != 2'(i % 4)) errs++;
      if (q_bl[i] != BLW'((i / 4) % N_BL)) errs++;
      if (q_last[i] != (i == N_BL * 4 - 1)) errs++;
    end
    chk("win_seq_errs", errs, 0);
    nt = '1;
    if (q_bl.size() > N_BL * 4) nt = q_bl[N_BL*4];
    chk("win_next_tag", nt, 0);

    clr();
    push(acc_pat(10), 1'b0);
    wait_stk(1, "stall");
    dout.out_ready = 1'b0;
    hold_d = dout.out_data;
    hold_s = dout.out_stokes;
    stable = 1'b1;
    repeat (10) begin
      step(1);
      if (dout.out_data !== hold_d || dout.out_stokes !== hold_s ||
          !dout.out_valid) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    chk("stall_held", {hold_s, hold_d}, {2'd1, mk(11, -11)});
    dout.out_ready = 1'b1;
    step(8);
    chk("stall_beats", q_stk.size(), 4);
    errs = 0;
    for (int i = 0; i < q_stk.size(); i++)
      if (q_stk[i] != 2'(i) || q_data[i] != mk(10 + i, -(10 + i)) ||
          q_bl[i] != 10'd1) errs++;
    chk("stall_seq_errs", errs, 0);

    clr();
    dout.out_ready = 1'b0;
    push(acc_pat(0), 1'b0);
    step(3);
    push(acc_pat(1), 1'b1);
    for (int i = 1; i < 16; i++) push(acc_pat(i + 1), 1'b0);
    chk("ovf_full_clear", overflow, 0);
    push(acc_pat(99), 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", {dout.out_valid, dout.out_stokes, dout.out_bl},
        {1'b1, 2'd0, 10'd2});
    dout.out_ready = 1'b1;
    step(3);
    push(acc_pat(200), 1'b0);
    step(85);
    collect();
    chk("ovf_words", wtag.size(), 18);
    errs = 0;
    for (int i = 0; i < wtag.size() && i < 18; i++)
      if (wtag[i] != ((i == 0) ? 2 : (i == 17) ? 17 : i - 1)) errs++;
    chk("ovf_tag_errs", errs, 0);
    nt = '0;
    if (wdat.size() == 18 && wdat[17] == mk(200, -200)) nt = 10'd1;
    chk("ovf_last_data", nt, 1);
    chk("ovf_sticky", overflow, 1);

    clr();
    push(acc_pat(30), 1'b0);
    wait_stk(2, "rst_mid");
    rst_n = 1'b0;
    #1;
    chk("rstmid_flags", {dout.out_valid, dout.out_last, overflow}, 0);
    chk("rstmid_regs", {dout.out_stokes, dout.out_bl, dout.out_data}, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    clr();
    push(acc_pat(50), 1'b0);
    step(8);
    chk("rstmid_beats", q_stk.size(), 4);
    if (q_stk.size() > 0)
      chk("rstmid_first", {q_stk[0], q_bl[0], q_data[0]},
          {2'd0, 10'd0, mk(50, -50)});

    clr();
    push(acc_pat(0), 1'b1);
    for (int i = 1; i < 98; i++) begin
      step(3);
      push(acc_pat(i), 1'b0);
    end
    step(3);
    push(acc_pat(98), 1'b0);
    push(acc_pat(99), 1'b0);
    push(acc_pat(5), 1'b1);
    push(acc_pat(6), 1'b0);
    step(30);
    collect();
    chk("sync_words", wtag.size(), 102);
    errs = 0;
    for (int i = 0; i < wtag.size() && i < 102; i++)
      if (wtag[i] != ((i < 100) ? i : i - 100)) errs++;
    chk("sync_tag_errs", errs, 0);
    nt = '1;
    if (wdat.size() > 100 && wdat[100] == mk(5, -5)) nt = '0;
    chk("sync_word_data", nt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xeng_acc_unload.md
XENG_ACC_UNLOAD -- requirements
Module: xeng_acc_unload

Interface
REQ-001 Parameter SERIAL_ACC_LEN_BITS, default 7, sets log2 of the serial accumulation length.
REQ-002 Parameter P_FACTOR_BITS, default 2, sets log2 of the parallel cmult factor.
REQ-003 Parameter BITWIDTH, default 4, sets the real/imag bits per input sample.
REQ-004 Parameter N_POLS, default 2, is the number of polarizations; N_STOKES = N_POLS*N_POLS.
REQ-005 Parameter N_ANTS, default 32, is the number of dual-pol antennas.
REQ-006 Parameter FIFO_DEPTH_BITS, default 4, sets log2 of the word FIFO depth.
REQ-007 Derived constants: CW = 2*BITWIDTH+1+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS (18); ACC_WIDTH = N_STOKES*2*CW (144); N_BL = N_ANTS*((N_ANTS>>1)+1) (544); BLW = clog2(N_BL).
REQ-008 clk  input  1  single clock; all logic rising-edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 ce  input  1  clock enable; when low, all state holds.
REQ-011 sync_in  input  1  window-start pulse from the last tap's sync output.
REQ-012 acc_in  input  ACC_WIDTH  accumulation word from the end of the tap chain.
REQ-013 valid_in  input  1  acc_in qualifier; no backpressure toward the chain.
REQ-014 out_data  output  2*CW  one Stokes product, real in the upper CW bits, imag in the lower CW bits.
REQ-015 out_stokes  output  clog2(N_STOKES)  Stokes index of out_data.
REQ-016 out_bl  output  BLW  baseline index of out_data.
REQ-017 out_last  output  1  final Stokes of baseline N_BL-1.
REQ-018 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-019 overflow  output  1  sticky flag: a word was dropped.

Function
REQ-020 Stokes s of acc_in SHALL occupy bits [(s+1)*2*CW-1 : s*2*CW], real above imag.
REQ-021 Each accepted word SHALL be stored in the FIFO with its baseline tag; the baseline counter increments per accepted word and wraps from N_BL-1 to 0.
REQ-022 sync_in high SHALL load the baseline counter so that a word with valid_in in the same cycle gets tag 0 and the following word gets tag 1; the FIFO is not flushed.
REQ-023 Each FIFO word SHALL be emitted as N_STOKES beats, with out_stokes running 0..N_STOKES-1 and out_bl constant.
REQ-024 A beat transfers when out_valid and out_ready are both high; the outputs hold stable while out_valid is high and out_ready is low.
REQ-025 Latency: with the FIFO empty and out_ready high, valid_in at cycle t SHALL give the stokes-0 beat at t+2, then one beat per cycle.
REQ-026 The serializer SHALL pop the next word with no bubble after the last beat.
REQ-027 valid_in with the FIFO full and no pop that cycle SHALL drop the word, set overflow, and still advance the baseline counter.
REQ-028 A simultaneous push and pop on a full FIFO SHALL accept the word.
REQ-029 out_last = out_valid AND (out_stokes == N_STOKES-1) AND (out_bl == N_BL-1).
REQ-030 Serializer states: IDLE (FIFO empty) -> EMIT (beats 0..N_STOKES-1) -> EMIT or IDLE depending on FIFO occupancy.

Reset
REQ-031 rst_n low SHALL immediately clear out_valid, out_last, overflow, out_stokes, out_bl, out_data, the FIFO pointers, the baseline counter and the state (IDLE).
REQ-032 Reset asserted mid-word SHALL discard the partial word; after release, the first beat is stokes 0 of the next accepted word.
REQ-033 overflow SHALL clear only on reset.

Structure
REQ-034 CW, ACC_WIDTH, N_STOKES, N_BL and clog2 SHALL live in a shared package, xeng_acc_pkg.
REQ-035 The storage SHALL be one sub-module, acc_word_fifo: synchronous FIFO, width ACC_WIDTH+BLW, with full/empty flags.

Verification
REQ-036 Reset, then a single valid_in with stokes s = {re:s+1, im:-(s+1)}, out_ready=1 -> beats at t+2..t+5 with out_bl 0, out_stokes 0..3 and the matching data.
REQ-037 sync_in plus valid_in, then 543 more valid words spaced 4 cycles apart -> tags 0..543, out_last only on the final beat, and the next word is tagged 0.
REQ-038 out_ready held low 10 cycles mid-word -> out_data/out_stokes stable, no beat lost or duplicated.
REQ-039 out_ready=0, then 17 back-to-back words with depth 16 -> overflow=1, word 17 absent, and the following word is tagged 17.
REQ-040 rst_n pulsed low during stokes 2 -> out_valid=0 the same cycle; after release, a new word emits from stokes 0 with tag 0.
REQ-041 sync_in mid-window (tag 100) -> the coincident word is tagged 0, and earlier FIFO words drain with their original tags.
